// File: rtl/gpu_csr_pkg.sv
// Shared register map, access types and defaults for the GPU control/status register bank.
package gpu_csr_pkg;

    localparam int unsigned REG_STATUS   = 0;
    localparam int unsigned REG_CONTROL  = 1;
    localparam int unsigned REG_IRQ_STAT = 2;
    localparam int unsigned REG_IRQ_EN   = 3;
    localparam int unsigned REG_COMMAND  = 4;
    localparam int unsigned REG_SCRATCH  = 5;
    localparam int unsigned REG_VERSION  = 6;
    localparam int unsigned REG_CYCLES   = 7;

    localparam logic [31:0] VERSION_DEFAULT = 32'h0001_0000;

    typedef enum logic [2:0] {
        ACC_RO,
        ACC_RW,
        ACC_W1C,
        ACC_WO,
        ACC_RC
    } access_e;

endpackage

// File: rtl/gpu_irq_ctrl.sv
// Sticky interrupt status with write-one-to-clear, enable mask and registered level interrupt.
module gpu_irq_ctrl #(
    parameter int unsigned IRQ_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IRQ_BITS-1:0] events,
    input  logic [IRQ_BITS-1:0] clr,
    input  logic [IRQ_BITS-1:0] en_mask,
    input  logic [IRQ_BITS-1:0] en_data,
    output logic [IRQ_BITS-1:0] status,
    output logic [IRQ_BITS-1:0] enable,
    output logic                irq
);

    // A new event overrides a same-cycle clear so no edge is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= '0;
            enable <= '0;
            irq    <= 1'b0;
        end else begin
            status <= (status & ~clr) | events;
            enable <= (enable & ~en_mask) | (en_data & en_mask);
            irq    <= |(status & enable);
        end
    end

endmodule

// File: rtl/gpu_csr_bank.sv
// Host-facing control/status register bank for the GPU core: one-cycle reads, byte-enabled writes.
module gpu_csr_bank
    import gpu_csr_pkg::*;
#(
    parameter int unsigned  BYTES_PER_REG = 4,
    parameter int unsigned  REG_COUNT     = 8,
    parameter int unsigned  IRQ_BITS      = 8,
    parameter logic [31:0]  VERSION       = VERSION_DEFAULT,
    localparam int unsigned WIDTH         = 8 * BYTES_PER_REG,
    localparam int unsigned ADDR_BITS     = $clog2(REG_COUNT * BYTES_PER_REG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADDR_BITS-1:0]     addr,
    input  logic [BYTES_PER_REG-1:0] we,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic [WIDTH-1:0]         gpu_status,
    input  logic [IRQ_BITS-1:0]      irq_events,
    output logic [WIDTH-1:0]         gpu_control,
    output logic [WIDTH-1:0]         cmd_pulse,
    output logic                     irq
);

    localparam int unsigned BSEL = $clog2(BYTES_PER_REG);

    logic [ADDR_BITS-1:0] widx;
    logic [WIDTH-1:0]     wmask;
    logic [WIDTH-1:0]     rdata;
    logic [WIDTH-1:0]     scratch;
    logic [WIDTH-1:0]     cycles;
    logic                 wr_any;
    logic                 sel_ctrl;
    logic                 sel_stat;
    logic                 sel_ien;
    logic                 sel_cmd;
    logic                 sel_scr;
    logic                 sel_cyc;
    logic [IRQ_BITS-1:0]  irq_status;
    logic [IRQ_BITS-1:0]  irq_enable;
    logic [IRQ_BITS-1:0]  stat_clr;
    logic [IRQ_BITS-1:0]  ien_mask;

    assign widx     = addr >> BSEL;
    assign wr_any   = en & (|we);
    assign sel_ctrl = (widx == ADDR_BITS'(REG_CONTROL));
    assign sel_stat = (widx == ADDR_BITS'(REG_IRQ_STAT));
    assign sel_ien  = (widx == ADDR_BITS'(REG_IRQ_EN));
    assign sel_cmd  = (widx == ADDR_BITS'(REG_COMMAND));
    assign sel_scr  = (widx == ADDR_BITS'(REG_SCRATCH));
    assign sel_cyc  = (widx == ADDR_BITS'(REG_CYCLES));

    // Per-bit write mask, already qualified by the access strobe.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < int'(BYTES_PER_REG); i++) begin
            wmask[8*i +: 8] = {8{en & we[i]}};
        end
    end

    assign stat_clr = sel_stat ? (din[IRQ_BITS-1:0] & wmask[IRQ_BITS-1:0]) : '0;
    assign ien_mask = sel_ien ? wmask[IRQ_BITS-1:0] : '0;

    gpu_irq_ctrl #(
        .IRQ_BITS (IRQ_BITS)
    ) u_irq (
        .clk     (clk),
        .rst     (rst),
        .events  (irq_events),
        .clr     (stat_clr),
        .en_mask (ien_mask),
        .en_data (din[IRQ_BITS-1:0]),
        .status  (irq_status),
        .enable  (irq_enable),
        .irq     (irq)
    );

    // Read mux sees register contents before this edge's write.
    always_comb begin
        rdata = '0;
        case (widx)
            ADDR_BITS'(REG_STATUS):   rdata = gpu_status;
            ADDR_BITS'(REG_CONTROL):  rdata = gpu_control;
            ADDR_BITS'(REG_IRQ_STAT): rdata = WIDTH'(irq_status);
            ADDR_BITS'(REG_IRQ_EN):   rdata = WIDTH'(irq_enable);
            ADDR_BITS'(REG_SCRATCH):  rdata = scratch;
            ADDR_BITS'(REG_VERSION):  rdata = WIDTH'(VERSION);
            ADDR_BITS'(REG_CYCLES):   rdata = cycles;
            default:                  rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout        <= '0;
            dout_valid  <= 1'b0;
            gpu_control <= '0;
            cmd_pulse   <= '0;
            scratch     <= '0;
            cycles      <= '0;
        end else begin
            dout_valid <= en;
            if (en) begin
                dout <= rdata;
            end
            if (sel_ctrl) begin
                gpu_control <= (gpu_control & ~wmask) | (din & wmask);
            end
            if (sel_scr) begin
                scratch <= (scratch & ~wmask) | (din & wmask);
            end
            cmd_pulse <= sel_cmd ? (din & wmask) : '0;
            // A write of any byte restarts the counter at zero.
            cycles    <= (sel_cyc && wr_any) ? '0 : cycles + WIDTH'(1);
        end
    end

endmodule
